alu_mul_sequencer: RTL and testbench

Iterative unsigned 32x32 -> 64-bit multiplier controller that borrows the shared structural ALU for its adds.
- Each iteration does one shift-add step: ALU ADD (OP=3'b100, DIFF=0) on the running high word, then a local 65-bit right shift.
- Sits beside the ALU in the execute stage. The core stalls on busy and consumes the product on done.
- Fixed latency, one iteration per clock.

---
 rtl/alu_ctrl_pkg.sv | 22 ++
 rtl/alu_mul_sequencer.sv | 86 ++++++++
 tb/tb_alu_mul_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: opcode encodings, datapath width and
// the multiply sequencer state encoding.
package alu_ctrl_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Iterative unsigned WIDTH x WIDTH multiplier that borrows the shared ALU
// for one shift-add step per clock; fixed latency, no early exit.
//
// state | meaning
// IDLE  | waiting for start; ALU operands held at zero
// EXEC  | one shift-add iteration per clock, N_ITER clocks
// DONE  | one-cycle done pulse, product valid
module alu_mul_sequencer #(
  parameter int         WIDTH  = alu_ctrl_pkg::WIDTH,
  parameter int         N_ITER = WIDTH,
  parameter logic [2:0] OP_ADD = alu_ctrl_pkg::OP_ADD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_diff,
  output logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_res,
  input  logic               alu_cy
);
  import alu_ctrl_pkg::*;

  localparam int CW = $clog2(N_ITER);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_EXEC = EXEC;
  localparam logic [1:0] ST_DONE = DONE;
  localparam logic [CW-1:0] CNT_LAST = CW'(N_ITER - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   mc;
  logic [2*WIDTH-1:0] step;

  // Carry lands in the top bit after the shift, so the product cannot overflow.
  assign step = {alu_cy, alu_res, lo[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      mc      <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mc    <= mcand;
            lo    <= mplier;
            hi    <= '0;
            cnt   <= '0;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          {hi, lo} <= step;
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            product <= step;
            state   <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign alu_a    = (state == ST_EXEC) ? hi : '0;
  assign alu_b    = (state == ST_EXEC && lo[0]) ? mc : '0;
  assign alu_op   = OP_ADD;
  assign alu_diff = 1'b0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: models the shared ALU adder and checks
// products through a scoreboard queue plus per-scenario timing checks.
module tb_alu_mul_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] mcand = '0;
  logic [31:0] mplier = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_diff;
  logic [2:0]  alu_op;
  logic [31:0] alu_res;
  logic        alu_cy;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  // Shared ALU in ADD mode: combinational, same-cycle result and carry.
  assign {alu_cy, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};

  alu_mul_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_diff(alu_diff), .alu_op(alu_op),
    .alu_res(alu_res), .alu_cy(alu_cy)
  );

  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done product=%h with no pending request", product);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (product !== e) begin
          errors++;
          $display("FAIL scoreboard_product got=%h exp=%h", product, e);
        end
      end
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    exp_q.push_back({32'b0, a} * {32'b0, b});
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge (cycle index 1).
  task automatic wait_done(output int n, output int busy_n, output logic [31:0] b_or);
    n = 1; busy_n = 0; b_or = '0;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      b_or |= alu_b;
      @(negedge clk);
      n++;
    end
    if (busy) busy_n++;
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout waited=%0d cycles", n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mcand = 32'd3; mplier = 32'd5;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b product=%h alu_a=%h alu_b=%h exp all zero",
               busy, done, product, alu_a, alu_b);
    end
    checks++;
    if (alu_op !== 3'b100 || alu_diff !== 1'b0) begin
      errors++;
      $display("FAIL alu_ctrl_const op=%b diff=%b exp op=100 diff=0", alu_op, alu_diff);
    end
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n, bn; logic [31:0] bo;
    start_op(32'd3, 32'd5);
    checks++;
    if (alu_op !== 3'b100 || alu_diff !== 1'b0) begin
      errors++;
      $display("FAIL exec_alu_ctrl op=%b diff=%b exp op=100 diff=0", alu_op, alu_diff);
    end
    wait_done(n, bn, bo);
    checks++;
    if (n !== 33) begin errors++; $display("FAIL basic_latency got=%0d exp=33", n); end
    checks++;
    if (bn !== 33) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=33", bn); end
    checks++;
    if (product !== 64'h0000_0000_0000_000F) begin
      errors++; $display("FAIL basic_product got=%h exp=%h", product, 64'hF);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_after_done busy=%b done=%b exp 0 0", busy, done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (product !== 64'h0000_0000_0000_000F) begin
      errors++; $display("FAIL basic_product_hold got=%h exp=%h", product, 64'hF);
    end
  endtask

  task automatic test_carry();
    int n, bn; logic [31:0] bo;
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n, bn, bo);
    checks++;
    if (product !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL carry_product got=%h exp=%h", product, 64'hFFFF_FFFE_0000_0001);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_mplier();
    int n, bn; logic [31:0] bo;
    start_op(32'h1234_5678, 32'h0);
    wait_done(n, bn, bo);
    checks++;
    if (n !== 33) begin errors++; $display("FAIL zero_latency got=%0d exp=33", n); end
    checks++;
    if (bo !== 32'h0) begin errors++; $display("FAIL zero_alu_b got_or=%h exp=0", bo); end
    checks++;
    if (product !== 64'h0) begin errors++; $display("FAIL zero_product got=%h exp=0", product); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int n = 1;
    int extra = 0;
    int busy_seen = 0;
    start_op(32'd100, 32'd200);
    while (!done && n < 40) begin
      if (n == 10) begin start = 1'b1; mcand = 32'd7; mplier = 32'd9; end
      if (n == 11) start = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done || n !== 33) begin
      errors++; $display("FAIL ignore_latency done=%b cycle=%0d exp done at 33", done, n);
    end
    checks++;
    if (product !== 64'd20000) begin
      errors++; $display("FAIL ignore_product got=%h exp=%h", product, 64'd20000);
    end
    start = 1'b1; mcand = 32'd7; mplier = 32'd9;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) extra++;
      if (busy) busy_seen++;
      @(negedge clk);
    end
    checks++;
    if (extra !== 0 || busy_seen !== 0) begin
      errors++; $display("FAIL ignore_no_second_op dones=%0d busy_cycles=%0d exp 0 0", extra, busy_seen);
    end
  endtask

  task automatic test_reset_mid();
    int n, bn; logic [31:0] bo;
    @(negedge clk);
    start = 1'b1; mcand = 32'hDEAD_BEEF; mplier = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0 || alu_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b product=%h alu_a=%h exp all zero",
               busy, done, product, alu_a);
    end
    rst = 1'b0; start = 1'b0;
    start_op(32'h8000_0000, 32'd2);
    wait_done(n, bn, bo);
    checks++;
    if (product !== 64'h0000_0001_0000_0000) begin
      errors++; $display("FAIL reset_mid_next got=%h exp=%h", product, 64'h1_0000_0000);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int prev = -1;
    int ndone = 0;
    int n, bn; logic [31:0] bo;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 103; i++) begin
      if (done) begin
        if (prev >= 0) begin
          checks++;
          if (i - prev !== 34) begin
            errors++; $display("FAIL b2b_spacing got=%0d exp=34", i - prev);
          end
        end
        prev = i;
        ndone++;
      end
      mcand  = $urandom;
      mplier = $urandom;
      if (!busy) exp_q.push_back({32'b0, mcand} * {32'b0, mplier});
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(n, bn, bo);
    @(negedge clk);
    checks++;
    if (ndone !== 3) begin errors++; $display("FAIL b2b_done_count got=%0d exp=3", ndone); end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL b2b_pending got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero_mplier();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
